bus_sched: RTL and testbench
============================

BUS_SCHED -- requirements
Module: bus_sched

Interface
REQ-001 Parameter TIMEOUT, default 8'd64, number of BUSY cycles without slvACKI before the cycle is declared non-existent memory (NXM); legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 cslREQI  input  1  console bus request; highest priority.
REQ-005 ubaREQI  input  1  Unibus adapter DMA bus request; middle priority.
REQ-006 cpuREQI  input  1  CPU bus request; lowest priority.
REQ-007 slvACKI  input  1  OR of all responder acknowledges (memory, UBA, console).
REQ-008 addrI  input  36  bus address [0:35] driven by current owner.
REQ-009 cslGNTO, ubaGNTO, cpuGNTO  output  1 each  registered bus grant; at most one high.
REQ-010 cslACKO, ubaACKO, cpuACKO  output  1 each  registered one-cycle acknowledge to owner.
REQ-011 nxmO  output  1  registered one-cycle pulse, coincident with the timeout ACK.
REQ-012 nxmADDRO  output  36  address latched at NXM timeout; holds until next NXM or reset.
REQ-013 busyO  output  1  high in BUSY and WAIT.

Function
REQ-014 States: IDLE, BUSY, WAIT; 2-bit encoding; unreachable encodings return to IDLE next cycle.
REQ-015 IDLE: grants low; if any REQ high, next edge asserts GNT of highest-priority requester (csl > uba > cpu), clears counter, enters BUSY.
REQ-016 Simultaneous requests in IDLE: only highest-priority one granted; others stay pending, no ACK.
REQ-017 No preemption: higher-priority REQ arriving during BUSY or WAIT waits until return to IDLE.
REQ-018 BUSY: owner GNT held; 8-bit counter increments by 1 each BUSY cycle with slvACKI low.
REQ-019 BUSY with slvACKI high: next edge pulses owner ACKO for exactly one cycle, nxmO low, enter WAIT.
REQ-020 BUSY with counter == TIMEOUT-1 and slvACKI low: next edge pulses owner ACKO and nxmO for one cycle, latches addrI into nxmADDRO, enter WAIT.
REQ-021 slvACKI and timeout in same cycle: normal ACK wins, nxmO low, nxmADDRO unchanged.
REQ-022 BUSY with owner REQ low (abort): next edge drops GNT, no ACK, enter IDLE; counter cleared.
REQ-023 WAIT: owner GNT held; slvACKI ignored; when owner REQ low, next edge drops GNT, enters IDLE.
REQ-024 Minimum one IDLE cycle (all grants low) between consecutive ownerships.
REQ-025 ACK latency: ACKO rises on the first edge after slvACKI sampled high in BUSY; earliest ACK is 2 cycles after REQ asserted from IDLE.
REQ-026 Counter saturates, never wraps; cleared on entry to BUSY.
REQ-027 ACKO only ever asserted to the current grant holder; never two ACKOs at once.

Reset
REQ-028 rst_n low: immediately state IDLE, counter 0, all GNTO/ACKO low, nxmO 0, busyO 0, nxmADDRO 36'o0, regardless of state.
REQ-029 Reset mid-BUSY or mid-WAIT: transaction discarded, no ACK issued; after rst_n rises, arbitration restarts from IDLE on next edge.

Verification
REQ-030 cpuREQI high at cycle 0, slvACKI high at cycle 3 -> cpuGNTO high cycles 1..until REQ drop, cpuACKO high only cycle 4, nxmO 0.
REQ-031 cslREQI and cpuREQI high same cycle, each acked after 2 cycles -> cslGNTO first; after csl drops REQ, one idle cycle, then cpuGNTO.
REQ-032 ubaREQI high, addrI=36'o000000017777, slvACKI never -> at BUSY cycle 64 ubaACKO and nxmO pulse together, nxmADDRO=36'o000000017777.
REQ-033 cpu owns bus (BUSY), cslREQI rises -> no preemption; csl granted only after cpu ACK, cpu REQ drop, one IDLE cycle.
REQ-034 rst_n pulsed low during BUSY with ubaGNTO high -> all outputs 0 asynchronously, no ubaACKO; after release, still-high ubaREQI regranted next edge.
REQ-035 slvACKI rises on exactly the timeout cycle -> normal ACK, nxmO 0, nxmADDRO unchanged.

Source files
------------

// File: rtl/bus_sched.sv
// Fixed-priority bus scheduler (console > Unibus adapter > CPU) with ACK routing and a
// non-existent-memory timeout that acknowledges the owner and records the failing address.
module bus_sched #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cslREQI,
  input  logic        ubaREQI,
  input  logic        cpuREQI,
  input  logic        slvACKI,
  input  logic [35:0] addrI,
  output logic        cslGNTO,
  output logic        ubaGNTO,
  output logic        cpuGNTO,
  output logic        cslACKO,
  output logic        ubaACKO,
  output logic        cpuACKO,
  output logic        nxmO,
  output logic [35:0] nxmADDRO,
  output logic        busyO
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StWait = 2'b10
  } state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [2:0]  r_gnt, w_gnt_d;   // {csl, uba, cpu}
  logic [2:0]  r_ack, w_ack_d;
  logic        r_nxm, w_nxm_d;
  logic [35:0] r_nxm_addr, w_nxm_addr_d;

  logic [2:0]  w_req;
  logic        w_owner_req;

  assign w_req       = {cslREQI, ubaREQI, cpuREQI};
  assign w_owner_req = |(r_gnt & w_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_gnt      <= 3'b000;
      r_ack      <= 3'b000;
      r_nxm      <= 1'b0;
      r_nxm_addr <= 36'o0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_gnt      <= w_gnt_d;
      r_ack      <= w_ack_d;
      r_nxm      <= w_nxm_d;
      r_nxm_addr <= w_nxm_addr_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_gnt_d      = r_gnt;
    w_ack_d      = 3'b000;
    w_nxm_d      = 1'b0;
    w_nxm_addr_d = r_nxm_addr;
    case (r_state)
      StIdle: begin
        w_gnt_d = 3'b000;
        if (|w_req) begin
          if (cslREQI)      w_gnt_d = 3'b100;
          else if (ubaREQI) w_gnt_d = 3'b010;
          else              w_gnt_d = 3'b001;
          w_cnt_d   = 8'd0;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        // Abort takes precedence: an owner that withdrew its request gets no ACK.
        if (!w_owner_req) begin
          w_gnt_d   = 3'b000;
          w_cnt_d   = 8'd0;
          w_state_d = StIdle;
        end else if (slvACKI) begin
          w_ack_d   = r_gnt;
          w_state_d = StWait;
        end else if (r_cnt == TIMEOUT - 8'd1) begin
          w_ack_d      = r_gnt;
          w_nxm_d      = 1'b1;
          w_nxm_addr_d = addrI;
          w_state_d    = StWait;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StWait: begin
        if (!w_owner_req) begin
          w_gnt_d   = 3'b000;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_gnt_d   = 3'b000;
        w_cnt_d   = 8'd0;
        w_state_d = StIdle;
      end
    endcase
  end

  assign cslGNTO  = r_gnt[2];
  assign ubaGNTO  = r_gnt[1];
  assign cpuGNTO  = r_gnt[0];
  assign cslACKO  = r_ack[2];
  assign ubaACKO  = r_ack[1];
  assign cpuACKO  = r_ack[0];
  assign nxmO     = r_nxm;
  assign nxmADDRO = r_nxm_addr;
  assign busyO    = (r_state == StBusy) || (r_state == StWait);

endmodule

// File: tb/tb_bus_sched.sv
// Bench for bus_sched: directed scenarios then random traffic, every cycle compared against
// a transaction-level model of ownership, elapsed busy time and acknowledge routing.
module tb_bus_sched;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cslREQI, ubaREQI, cpuREQI, slvACKI;
  logic [35:0] addrI;
  logic        cslGNTO, ubaGNTO, cpuGNTO, cslACKO, ubaACKO, cpuACKO, nxmO, busyO;
  logic [35:0] nxmADDRO;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner index (2=csl,1=uba,0=cpu,-1=none), phase (0 idle,1 busy,2 wait).
  int          m_owner, m_phase, m_elapsed, m_ack_to;
  logic        m_nxm;
  logic [35:0] m_nxm_addr;

  bus_sched #(.TIMEOUT(8'd64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cslREQI  (cslREQI),
    .ubaREQI  (ubaREQI),
    .cpuREQI  (cpuREQI),
    .slvACKI  (slvACKI),
    .addrI    (addrI),
    .cslGNTO  (cslGNTO),
    .ubaGNTO  (ubaGNTO),
    .cpuGNTO  (cpuGNTO),
    .cslACKO  (cslACKO),
    .ubaACKO  (ubaACKO),
    .cpuACKO  (cpuACKO),
    .nxmO     (nxmO),
    .nxmADDRO (nxmADDRO),
    .busyO    (busyO)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] observed();
    return {cslGNTO, ubaGNTO, cpuGNTO, cslACKO, ubaACKO, cpuACKO, nxmO, busyO, nxmADDRO};
  endfunction

  function automatic logic [43:0] expected();
    logic [2:0] g = 3'b000;
    logic [2:0] a = 3'b000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    if (m_ack_to >= 0) a[m_ack_to] = 1'b1;
    return {g, a, m_nxm, (m_phase != 0), m_nxm_addr};
  endfunction

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_elapsed = 0; m_ack_to = -1; m_nxm = 1'b0; m_nxm_addr = '0;
  endtask

  // One bus transaction step using the inputs seen at the clock edge.
  task automatic model_step();
    logic [2:0] r = {cslREQI, ubaREQI, cpuREQI};
    m_ack_to = -1;
    m_nxm    = 1'b0;
    if (m_phase == 0) begin
      if (r != 3'b000) begin
        m_owner   = r[2] ? 2 : (r[1] ? 1 : 0);
        m_elapsed = 0;
        m_phase   = 1;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_elapsed++;
      if (slvACKI) begin
        m_ack_to = m_owner;
        m_phase  = 2;
      end else if (m_elapsed == TO) begin
        m_ack_to   = m_owner;
        m_nxm      = 1'b1;
        m_nxm_addr = addrI;
        m_phase    = 2;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag, observed(), expected());
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check(tag, observed(), 44'h0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {cslREQI, ubaREQI, cpuREQI, slvACKI} = 4'b0000;
    addrI = '0;
    model_reset();
    #3;
    check("reset_state", observed(), 44'h0);
    #3 rst_n = 1'b1;
    cycle("idle");

    // Single CPU transfer, ACK sampled in the third busy cycle.
    cpuREQI = 1'b1;
    cycle("r030_c1"); cycle("r030_c2"); cycle("r030_c3");
    slvACKI = 1'b1;
    cycle("r030_c4");
    check("r030_ack", {cpuGNTO, cpuACKO, nxmO}, 44'b110);
    slvACKI = 1'b0;
    cycle("r030_c5");
    check("r030_ack_single", {cpuGNTO, cpuACKO}, 44'b10);
    cpuREQI = 1'b0;
    cycle("r030_drop");

    // Simultaneous console and CPU requests.
    cslREQI = 1'b1; cpuREQI = 1'b1;
    cycle("r031_g");
    check("r031_csl_first", {cslGNTO, cpuGNTO}, 44'b10);
    cycle("r031_b");
    slvACKI = 1'b1;
    cycle("r031_ack1");
    check("r031_csl_ack", {cslACKO, cpuACKO}, 44'b10);
    slvACKI = 1'b0; cslREQI = 1'b0;
    cycle("r031_idle");
    check("r031_gap", {cslGNTO, ubaGNTO, cpuGNTO}, 44'b000);
    cycle("r031_cpu");
    check("r031_cpu_gnt", {cslGNTO, cpuGNTO}, 44'b01);
    cycle("r031_cb");
    slvACKI = 1'b1;
    cycle("r031_ack2");
    slvACKI = 1'b0; cpuREQI = 1'b0;
    cycle("r031_end"); cycle("r031_end2");

    // Non-existent memory timeout on the Unibus adapter.
    ubaREQI = 1'b1; addrI = 36'o000000017777;
    for (int i = 0; i < TO; i++) cycle("r032_wait");
    check("r032_not_yet", {ubaACKO, nxmO}, 44'b00);
    cycle("r032_to");
    check("r032_nxm", {ubaACKO, nxmO, nxmADDRO}, {2'b11, 36'o000000017777});
    ubaREQI = 1'b0; addrI = 36'o123456701234;
    cycle("r032_w"); cycle("r032_i");

    // No preemption of a CPU owner by the console.
    cpuREQI = 1'b1;
    cycle("r033_g");
    cslREQI = 1'b1;
    cycle("r033_b");
    check("r033_nopreempt", {cslGNTO, cpuGNTO}, 44'b01);
    slvACKI = 1'b1;
    cycle("r033_ack");
    slvACKI = 1'b0; cpuREQI = 1'b0;
    cycle("r033_idle");
    cycle("r033_csl");
    check("r033_csl_gnt", {cslGNTO, cpuGNTO}, 44'b10);
    cslREQI = 1'b0;
    cycle("r033_e"); cycle("r033_e2");

    // ACK arriving on the very cycle the timeout would fire.
    cpuREQI = 1'b1;
    for (int i = 0; i < TO; i++) cycle("r035_wait");
    slvACKI = 1'b1;
    cycle("r035_ack");
    check("r035_normal", {cpuACKO, nxmO, nxmADDRO}, {2'b10, 36'o000000017777});
    slvACKI = 1'b0; cpuREQI = 1'b0;
    cycle("r035_e"); cycle("r035_e2");

    // Reset while the adapter owns the bus.
    ubaREQI = 1'b1;
    cycle("r034_g"); cycle("r034_b");
    pulse_reset("r034_async");
    cycle("r034_regrant");
    check("r034_uba_again", {ubaGNTO, ubaACKO, nxmADDRO}, 44'b10 << 36);
    ubaREQI = 1'b0;
    cycle("r034_e");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, cslREQI ? 63 : 15) == 0) cslREQI = ~cslREQI;
      if ($urandom_range(0, ubaREQI ? 63 : 15) == 0) ubaREQI = ~ubaREQI;
      if ($urandom_range(0, cpuREQI ? 63 : 7) == 0)  cpuREQI = ~cpuREQI;
      slvACKI = ($urandom_range(0, 39) == 0);
      addrI   = {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 499) == 0) pulse_reset("rand_reset");
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
